// File: rtl/seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_capture_decoder
// Purpose  : Samples an active-low 7-segment bus {a..g}. It waits until the
//            pattern has been stable for STABLE_CYCLES clocks, then converts
//            each newly stable pattern back into a BCD digit {W,X,Y,Z}.
//            Results are offered through a valid/ack handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   a..g       in   segment bus, active-low, a = MSB of the pattern
//   out_ack    in   consumer accepts the pending result
//   W,X,Y,Z    out  decoded BCD digit (W = MSB), 1111 for blank/error
//   out_valid  out  a result is pending
//   err        out  pending result is an unknown pattern
//   blank      out  pending result is the all-off pattern
//   overrun    out  sticky: an event was dropped while a result was pending
//   err_count  out  saturating count of error events
// ============================================================================
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       out_ack,
    output logic       W,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic       out_valid,
    output logic       err,
    output logic       blank,
    output logic       overrun,
    output logic [3:0] err_count
);

    localparam logic [7:0] c_STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [6:0] c_SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] c_BCD_NONE   = 4'b1111;
    localparam logic [3:0] c_ERR_MAX    = 4'd15;

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [6:0] w_seg_in;
    logic [6:0] seg_q;
    logic [6:0] last_acc_q;
    logic [7:0] stab_cnt_q;
    logic [7:0] stab_cnt_d;

    logic [0:0] state_q;
    logic [0:0] state_d;

    logic [3:0] bcd_q;
    logic       err_q;
    logic       blank_q;
    logic       overrun_q;
    logic [3:0] err_count_q;

    logic [3:0] w_dec_bcd;
    logic       w_dec_err;
    logic       w_dec_blank;
    logic       w_evt;
    logic       w_load;
    logic       w_drop;

    assign w_seg_in = {a, b, c, d, e, f, g};

    // Run-length of identical samples, restarted at 1 on any change and
    // parked at the threshold so a held pattern does not wrap the counter.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (w_seg_in != seg_q) begin
            stab_cnt_d = 8'd1;
        end else if (stab_cnt_q < c_STABLE_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end
    end

    // Comparing against the last accepted pattern gives exactly one event per
    // distinct stable pattern. It also suppresses a return to that pattern
    // after a short glitch.
    assign w_evt = (stab_cnt_q == c_STABLE_MAX) && (seg_q != last_acc_q);

    // Inverse of the display decoder's code table.
    always_comb begin
        w_dec_bcd   = c_BCD_NONE;
        w_dec_err   = 1'b0;
        w_dec_blank = 1'b0;
        case (seg_q)
            7'b0000001: w_dec_bcd = 4'd0;
            7'b1001111: w_dec_bcd = 4'd1;
            7'b0010010: w_dec_bcd = 4'd2;
            7'b0000110: w_dec_bcd = 4'd3;
            7'b1001100: w_dec_bcd = 4'd4;
            7'b0100100: w_dec_bcd = 4'd5;
            7'b0100000: w_dec_bcd = 4'd6;
            7'b0001111: w_dec_bcd = 4'd7;
            7'b0000000: w_dec_bcd = 4'd8;
            7'b0000100: w_dec_bcd = 4'd9;
            c_SEG_BLANK: w_dec_blank = 1'b1;
            default:     w_dec_err   = 1'b1;
        endcase
    end

    // An ack in the same cycle as an event frees the slot for the new result.
    assign w_load = w_evt && ((state_q == c_ST_EMPTY) || out_ack);
    assign w_drop = w_evt && (state_q == c_ST_FULL) && !out_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_EMPTY: begin
                if (w_evt) begin
                    state_d = c_ST_FULL;
                end
            end
            c_ST_FULL: begin
                if (out_ack && !w_evt) begin
                    state_d = c_ST_EMPTY;
                end
            end
            default: state_d = c_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= c_SEG_BLANK;
            stab_cnt_q  <= 8'd0;
            last_acc_q  <= c_SEG_BLANK;
            state_q     <= c_ST_EMPTY;
            bcd_q       <= c_BCD_NONE;
            err_q       <= 1'b0;
            blank_q     <= 1'b0;
            overrun_q   <= 1'b0;
            err_count_q <= 4'd0;
        end else begin
            seg_q      <= w_seg_in;
            stab_cnt_q <= stab_cnt_d;
            state_q    <= state_d;

            // last_acc and err_count track every event, dropped or not.
            if (w_evt) begin
                last_acc_q <= seg_q;
                if (w_dec_err && (err_count_q != c_ERR_MAX)) begin
                    err_count_q <= err_count_q + 4'd1;
                end
            end

            if (w_load) begin
                bcd_q   <= w_dec_bcd;
                err_q   <= w_dec_err;
                blank_q <= w_dec_blank;
            end

            if (w_drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign {W, X, Y, Z} = bcd_q;
    assign out_valid    = (state_q == c_ST_FULL);
    assign err          = err_q;
    assign blank        = blank_q;
    assign overrun      = overrun_q;
    assign err_count    = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_capture_decoder
// Purpose  : Self-checking bench for seg7_capture_decoder: table-driven
//            decode vectors, hand-written corner sequences and random
//            stimulus against a sample-history reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_capture_decoder;

    localparam int         S     = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic       a, b, c, d, e, f, g;
    logic       out_ack;
    logic       W, X, Y, Z;
    logic       out_valid, err, blank, overrun;
    logic [3:0] err_count;

    seg7_capture_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .out_ack   (out_ack),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .out_valid (out_valid),
        .err       (err),
        .blank     (blank),
        .overrun   (overrun),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [6:0] CODES [10];

    // Reference model state: every sample since reset, plus the result slot.
    logic [6:0] hist [$];
    logic [6:0] m_last;
    logic       m_valid;
    logic [3:0] m_bcd;
    logic       m_err;
    logic       m_blank;
    logic       m_ovr;
    int         m_errcnt;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] bcd;
        logic       e;
        logic       bl;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_vec();
        return {out_valid, W, X, Y, Z, err, blank, overrun, err_count};
    endfunction

    function automatic logic [11:0] model_vec();
        return {m_valid, m_bcd, m_err, m_blank, m_ovr, 4'(m_errcnt)};
    endfunction

    task automatic classify(input logic [6:0] p, output logic [3:0] dg,
                            output logic ee, output logic bb);
        dg = 4'hF;
        ee = 1'b1;
        bb = 1'b0;
        if (p == BLANK) begin
            ee = 1'b0;
            bb = 1'b1;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (CODES[i] == p) begin
                    dg = 4'(i);
                    ee = 1'b0;
                end
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_last   = BLANK;
        m_valid  = 1'b0;
        m_bcd    = 4'hF;
        m_err    = 1'b0;
        m_blank  = 1'b0;
        m_ovr    = 1'b0;
        m_errcnt = 0;
    endtask

    // One clock edge: an event exists if the last S samples are identical and
    // differ from the last accepted pattern.
    task automatic model_edge(input logic [6:0] s, input logic ack);
        logic       ev;
        logic [6:0] p;
        logic [3:0] dg;
        logic       ee, bb;
        ev = 1'b0;
        p  = BLANK;
        if (hist.size() >= S) begin
            p  = hist[hist.size() - 1];
            ev = (p != m_last);
            for (int i = 1; i < S; i++) begin
                if (hist[hist.size() - 1 - i] != p) ev = 1'b0;
            end
        end
        if (ev) begin
            m_last = p;
            classify(p, dg, ee, bb);
            if (ee && m_errcnt < 15) m_errcnt++;
            if (!m_valid || ack) begin
                m_valid = 1'b1;
                m_bcd   = dg;
                m_err   = ee;
                m_blank = bb;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && ack) begin
            m_valid = 1'b0;
        end
        hist.push_back(s);
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic step(input logic [6:0] s, input logic ack);
        {a, b, c, d, e, f, g} = s;
        out_ack = ack;
        @(posedge clk);
        #1;
        model_edge(s, ack);
        chk("model", dut_vec(), model_vec());
    endtask

    // Asynchronous assert between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset_async", dut_vec(), 12'h780);
        @(posedge clk);
        #1;
        chk("reset_held", dut_vec(), 12'h780);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] errs [16];
        logic [6:0] pat;
        logic [3:0] dg;
        logic       ee, bb;
        int         n;
        int         len;

        CODES = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

        for (int i = 0; i < 10; i++) tv[i] = '{CODES[i], 4'(i), 1'b0, 1'b0};
        tv[10] = '{BLANK,      4'hF, 1'b0, 1'b1};
        tv[11] = '{7'b1111101, 4'hF, 1'b1, 1'b0};
        tv[12] = '{7'b0110110, 4'hF, 1'b1, 1'b0};
        tv[13] = '{7'b1000000, 4'hF, 1'b1, 1'b0};

        {a, b, c, d, e, f, g} = BLANK;
        out_ack = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Idle blank bus: no event.
        repeat (20) step(BLANK, 1'b0);
        chk("idle_valid", 12'(out_valid), 12'd0);
        chk("idle_errcnt", 12'(err_count), 12'd0);

        // Latency: valid appears on the (S+1)th edge of a held pattern.
        for (int i = 1; i <= S + 1; i++) begin
            step(7'b0100100, 1'b0);
            chk("latency_valid", 12'(out_valid), 12'(i > S));
        end
        chk("digit5", 12'({W, X, Y, Z, err, blank}), 12'(6'b0101_00));
        repeat (6) step(7'b0100100, 1'b0);
        chk("no_second_event", 12'(out_valid), 12'd1);

        // Overrun: a new event while pending is dropped.
        repeat (6) step(7'b1001111, 1'b0);
        chk("overrun_set", 12'(overrun), 12'd1);
        chk("overrun_hold", 12'({W, X, Y, Z}), 12'h5);
        step(7'b1001111, 1'b1);
        chk("ack_clears", 12'(out_valid), 12'd0);
        repeat (6) step(7'b1001111, 1'b0);
        chk("last_acc_no_evt", 12'(out_valid), 12'd0);

        // Glitch rejection, then a stable error pattern.
        repeat (S + 1) step(7'b0000001, 1'b0);
        chk("digit0", 12'({out_valid, W, X, Y, Z}), 12'b1_0000);
        step(7'b0000001, 1'b1);
        repeat (2) step(7'b1111110, 1'b0);
        repeat (6) step(7'b0000001, 1'b0);
        chk("glitch_no_evt", 12'(out_valid), 12'd0);
        repeat (S + 1) step(7'b1111110, 1'b0);
        chk("err_evt", 12'({out_valid, W, X, Y, Z, err, blank}), 12'b1_1111_10);
        chk("err_count1", 12'(err_count), 12'd1);
        step(7'b1111110, 1'b1);

        // Table-driven decode.
        foreach (tv[i]) begin
            repeat (S + 1) step(tv[i].seg, 1'b0);
            chk("table", 12'({out_valid, W, X, Y, Z, err, blank}),
                12'({1'b1, tv[i].bcd, tv[i].e, tv[i].bl}));
            step(tv[i].seg, 1'b1);
            chk("table_ack", 12'(out_valid), 12'd0);
        end

        // Back-to-back events, each acked in its own load cycle.
        n = 0;
        for (int v = 0; v < 128; v++) begin
            pat = 7'(v);
            classify(pat, dg, ee, bb);
            if (ee && n < 16) begin
                errs[n] = pat;
                n++;
            end
        end
        for (int i = 0; i < 26; i++) begin
            pat = (i < 10) ? CODES[i] : errs[i - 10];
            repeat (S) step(pat, 1'b0);
            step(pat, 1'b1);
            chk("b2b", 12'({out_valid, W, X, Y, Z, err}),
                12'({1'b1, (i < 10) ? 4'(i) : 4'hF, (i >= 10)}));
        end
        chk("errcnt_sat", 12'(err_count), 12'd15);
        step(pat, 1'b1);
        chk("b2b_final_ack", 12'(out_valid), 12'd0);

        // Random runs against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 3:    pat = CODES[$urandom_range(0, 9)];
                1:       pat = BLANK;
                default: pat = 7'($urandom_range(0, 127));
            endcase
            len = $urandom_range(1, 7);
            repeat (len) step(pat, 1'($urandom_range(0, 2) == 0));
        end

        // Reset while a result is pending and overrun is set.
        do_reset();
        repeat (S + 1) step(7'b0010010, 1'b0);
        repeat (S + 2) step(7'b0001111, 1'b0);
        chk("pre_reset", 12'({out_valid, overrun, W, X, Y, Z}), 12'b11_0010);
        do_reset();
        repeat (3) step(BLANK, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
